// File: rtl/modulo_general_pkg.sv
// Shared definitions for the modulo_general setpoint controller.
//   - state_e         : controller FSM state encoding
//   - AMP_GAIN_DEFAULT: gain word for the programmable amplifier (-1 on both channels)
//   - bit-index constants for the amplifier load and the 34-clock ADC read frame
//   - measure()       : maps the top bits of a channel-A sample to an unsigned 8-bit value
package modulo_general_pkg;

  typedef enum logic [2:0] {
    AMP_LOAD = 3'd0,
    AMP_DONE = 3'd1,
    CONV     = 3'd2,
    READ     = 3'd3,
    UPDATE   = 3'd4
  } state_e;

  localparam logic [7:0] AMP_GAIN_DEFAULT = 8'h11;

  // Amplifier gain word is 8 bits, indices 0..7.
  localparam logic [5:0] AMP_LAST_IDX = 6'd7;

  // ADC frame: 34 SPI_CLK cycles, channel A occupies indices 2..15.
  localparam logic [5:0] READ_BITS     = 6'd34;
  localparam logic [5:0] READ_LAST_IDX = READ_BITS - 6'd1;
  localparam logic [5:0] CHA_FIRST_IDX = 6'd2;
  localparam logic [5:0] CHA_LAST_IDX  = 6'd15;

  localparam int unsigned CHA_WIDTH = 14;
  typedef logic [CHA_WIDTH-1:0] cha_sample_t;

  // Offset-binary conversion: flipping the sign bit of a[13:6] turns the
  // two's complement sample into an unsigned value centred on 0x80.
  function automatic logic [7:0] measure(input logic [7:0] a_hi);
    return {~a_hi[7], a_hi[6:0]};
  endfunction

endpackage

// File: rtl/modulo_general_spi_clk_gen.sv
// SPI clock divider with edge strobes.
//   clk, rst  : system clock, asynchronous active-low reset
//   en_i      : divider runs while high; held low the phase restarts at the
//               beginning of a low half-period
//   drive_i   : SPI_CLK pin follows the internal phase only while high
//   sclk_o    : registered SPI clock (idles low)
//   rise_o    : one-clk strobe, the coming edge raises the internal phase
//   fall_o    : one-clk strobe, the coming edge ends a full SPI_CLK period
module modulo_general_spi_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic drive_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic             sclk_q, sclk_d;
  logic             tick_s;

  // Divider next state; the phase toggles every CLK_DIV enabled cycles.
  always_comb begin
    tick_s = en_i && (div_q == DIV_LAST);
    if (!en_i) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (tick_s) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end else begin
      div_d   = div_q + DIV_W'(1);
      phase_d = phase_q;
    end
    // The pin is gated so it stays low between transfers while the period
    // timing keeps running.
    if (drive_i) begin
      sclk_d = phase_d;
    end else begin
      sclk_d = 1'b0;
    end
  end

  // Divider and SPI clock registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
    end
  end

  assign rise_o = tick_s & ~phase_q;
  assign fall_o = tick_s & phase_q;
  assign sclk_o = sclk_q;

endmodule

// File: rtl/modulo_general.sv
// Closed-loop PWM controller: programs the amplifier gain once, then
// repeatedly starts an ADC conversion, reads channel A over SPI, nudges the
// PWM duty one step toward the setpoint and drives the actuator.
//   clk, rst     : 50 MHz clock, asynchronous active-low reset
//   referencia   : unsigned 8-bit setpoint, looked at only in UPDATE
//   MISO         : ADC serial data, sampled on SPI_CLK rising edges
//   MOSI, CS_AMP : amplifier serial data / chip select (active low)
//   SPI_CLK      : shared SPI clock, idles low
//   ADC_Conv     : ADC conversion start pulse
//   PWM          : actuator drive
//   SPI_SS_B, DAC_CS, FPGA_INIT_B, AMP_Shunt : fixed levels keeping the
//                  other bus devices quiet and the amplifier powered
module modulo_general
  import modulo_general_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [7:0]  AMP_GAIN = AMP_GAIN_DEFAULT,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] referencia,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SPI_CLK,
  output logic       CS_AMP,
  output logic       ADC_Conv,
  output logic       PWM,
  output logic       SPI_SS_B,
  output logic       DAC_CS,
  output logic       FPGA_INIT_B,
  output logic       AMP_Shunt
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

  state_e              state_q, state_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  cha_sample_t         a_q, a_d;
  logic [7:0]          meas_s;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                mosi_q, mosi_d;
  logic                cs_amp_q, cs_amp_d;
  logic                adc_conv_q, adc_conv_d;
  logic                pwm_q, pwm_d;
  logic [2:0]          amp_idx_s;
  logic                sclk_en_s, sclk_drive_s, rise_s, fall_s, sclk_s;

  // The divider pauses for the single-clk UPDATE so each CONV starts on a
  // fresh low half-period.
  assign sclk_en_s = (state_q != UPDATE);

  modulo_general_spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_spi_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .en_i    (sclk_en_s),
    .drive_i (sclk_drive_s),
    .sclk_o  (sclk_s),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  // FSM state and SPI bit-index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= AMP_LOAD;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // FSM next state; every state except UPDATE lasts a whole number of
  // SPI_CLK periods, each period ending on a fall strobe.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      AMP_LOAD: begin
        if (fall_s && (bit_cnt_q == AMP_LAST_IDX)) begin
          state_d   = AMP_DONE;
          bit_cnt_d = '0;
        end else if (fall_s) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      AMP_DONE: begin
        if (fall_s) begin
          state_d = CONV;
        end else begin
          state_d = AMP_DONE;
        end
      end
      CONV: begin
        if (fall_s) begin
          state_d   = READ;
          bit_cnt_d = '0;
        end else begin
          state_d = CONV;
        end
      end
      READ: begin
        if (fall_s && (bit_cnt_q == READ_LAST_IDX)) begin
          state_d   = UPDATE;
          bit_cnt_d = '0;
        end else if (fall_s) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      UPDATE: begin
        // The amplifier is never revisited; only a reset reprograms it.
        state_d = CONV;
      end
      default: begin
        state_d   = AMP_LOAD;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Output decode, computed from the next state so the pins are registered
  // and line up with the state they belong to.
  always_comb begin
    sclk_drive_s = (state_d == AMP_LOAD) || (state_d == READ);
    cs_amp_d     = (state_d != AMP_LOAD);
    adc_conv_d   = (state_d == CONV);
    amp_idx_s    = 3'd7 - bit_cnt_d[2:0];
    // MOSI may move on any edge except one that raises SPI_CLK, so the
    // amplifier always sees a settled bit on its sampling edge.
    if (state_d == AMP_LOAD) begin
      if (rise_s) begin
        mosi_d = mosi_q;
      end else begin
        mosi_d = AMP_GAIN[amp_idx_s];
      end
    end else begin
      mosi_d = 1'b0;
    end
  end

  // Registered output pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_q     <= 1'b0;
      cs_amp_q   <= 1'b1;
      adc_conv_q <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      mosi_q     <= mosi_d;
      cs_amp_q   <= cs_amp_d;
      adc_conv_q <= adc_conv_d;
      pwm_q      <= pwm_d;
    end
  end

  // Channel-A shifter and the single-step duty controller.
  always_comb begin
    meas_s = measure(a_q[CHA_WIDTH-1:CHA_WIDTH-8]);
    if ((state_q == READ) && rise_s &&
        (bit_cnt_q >= CHA_FIRST_IDX) && (bit_cnt_q <= CHA_LAST_IDX)) begin
      a_d = {a_q[CHA_WIDTH-2:0], MISO};
    end else begin
      a_d = a_q;
    end
    duty_d = duty_q;
    if (state_q == UPDATE) begin
      if ((referencia > meas_s) && (duty_q != DUTY_MAX)) begin
        duty_d = duty_q + PWM_BITS'(1);
      end else if ((referencia < meas_s) && (duty_q != '0)) begin
        duty_d = duty_q - PWM_BITS'(1);
      end else begin
        duty_d = duty_q;
      end
    end else begin
      duty_d = duty_q;
    end
  end

  // PWM: the active duty is only swapped as the counter wraps to 0, so a
  // running period is never cut short or stretched.
  always_comb begin
    cnt_d = cnt_q + PWM_BITS'(1);
    if (cnt_q == DUTY_MAX) begin
      duty_act_d = duty_q;
    end else begin
      duty_act_d = duty_act_q;
    end
    pwm_d = (cnt_d < duty_act_d);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q        <= '0;
      duty_q     <= '0;
      duty_act_q <= '0;
      cnt_q      <= '0;
    end else begin
      a_q        <= a_d;
      duty_q     <= duty_d;
      duty_act_q <= duty_act_d;
      cnt_q      <= cnt_d;
    end
  end

  assign MOSI        = mosi_q;
  assign SPI_CLK     = sclk_s;
  assign CS_AMP      = cs_amp_q;
  assign ADC_Conv    = adc_conv_q;
  assign PWM         = pwm_q;
  assign SPI_SS_B    = 1'b1;
  assign DAC_CS      = 1'b1;
  assign FPGA_INIT_B = 1'b1;
  assign AMP_Shunt   = 1'b0;

endmodule

// File: tb/tb_modulo_general.sv
// Self-checking bench for modulo_general: ADC behaviour model on MISO,
// amplifier capture on MOSI, and a frame-level duty model.
module tb_modulo_general;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] referencia = 8'h00;
  logic       miso = 1'b0;
  logic       mosi, spi_clk, cs_amp, adc_conv, pwm;
  logic       spi_ss_b, dac_cs, fpga_init_b, amp_shunt;

  int checks   = 0;
  int failures = 0;

  // Current ADC frame contents, chosen by the stimulus at each frame start.
  logic [13:0] frame_a    = 14'h0000;
  logic        frame_junk = 1'b0;

  int         conv_cnt = 0;
  int         pwm_hi   = 0;
  int         amp_n    = 0;
  int         cs_fall  = 0;
  logic [7:0] amp_bits = 8'h00;
  int         adc_idx  = 0;
  bit         reading  = 1'b0;
  int         model_duty = 0;

  modulo_general dut (
    .clk         (clk),
    .rst         (rst),
    .referencia  (referencia),
    .MISO        (miso),
    .MOSI        (mosi),
    .SPI_CLK     (spi_clk),
    .CS_AMP      (cs_amp),
    .ADC_Conv    (adc_conv),
    .PWM         (pwm),
    .SPI_SS_B    (spi_ss_b),
    .DAC_CS      (dac_cs),
    .FPGA_INIT_B (fpga_init_b),
    .AMP_Shunt   (amp_shunt)
  );

  always #10 clk = ~clk;

  always @(posedge adc_conv) conv_cnt++;
  always @(negedge clk) if (pwm) pwm_hi++;
  always @(negedge cs_amp) cs_fall++;
  always @(posedge spi_clk) begin
    if (!cs_amp) begin
      amp_bits = {amp_bits[6:0], mosi};
      amp_n++;
    end
  end

  function automatic logic adc_bit(input int idx);
    if (idx >= 2 && idx <= 15) return frame_a[15-idx];
    return frame_junk;
  endfunction

  // ADC: presents bit 0 at conversion start, the next bit after every SPI_CLK fall.
  always @(posedge adc_conv or negedge spi_clk) begin
    if (adc_conv) begin
      adc_idx = 0;
      reading = 1'b1;
      miso    = adc_bit(0);
    end else if (reading) begin
      if (adc_idx < 33) begin
        adc_idx++;
        miso = adc_bit(adc_idx);
      end else begin
        reading = 1'b0;
      end
    end
  end

  // Measurement from the signed sample: shift range to 0..16383, keep top 8 bits.
  function automatic int meas_of(input logic [13:0] a);
    int s;
    s = a[13] ? int'(a) - 16384 : int'(a);
    return (s + 8192) / 64;
  endfunction

  function automatic int next_duty(input int d, input int r, input int m);
    if (r > m) return (d < 255) ? d + 1 : 255;
    if (r < m) return (d > 0) ? d - 1 : 0;
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_conv(output bit ok);
    int n0;
    n0 = conv_cnt;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (conv_cnt != n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One frame: check the duty left by the previous frame, then program this one.
  task automatic frame(input logic [13:0] a, input logic junk, input logic [7:0] r, input string tag);
    bit ok;
    wait_conv(ok);
    check({tag, "_conv_seen"}, 32'(ok), 32'd1);
    check(tag, 32'(dut.duty_q), 32'(model_duty));
    frame_a    = a;
    frame_junk = junk;
    referencia = r;
    model_duty = next_duty(model_duty, int'(r), meas_of(a));
  endtask

  task automatic wait_amp(input int a0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((amp_n - a0) >= 8 && cs_amp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pwm_window(input int exp, input string tag);
    int hi;
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm) hi++;
    end
    check(tag, 32'(hi), 32'(exp));
  endtask

  initial begin
    bit          ok;
    int          a0;
    int          p0;
    logic [13:0] ra;
    logic [7:0]  rr;

    // Reset
    #5 rst = 1'b0;
    #100;
    check("rst_cs_amp", 32'(cs_amp), 32'd1);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_spi_clk", 32'(spi_clk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_adc_conv", 32'(adc_conv), 32'd0);
    check("rst_spi_ss_b", 32'(spi_ss_b), 32'd1);
    check("rst_dac_cs", 32'(dac_cs), 32'd1);
    check("rst_fpga_init_b", 32'(fpga_init_b), 32'd1);
    check("rst_amp_shunt", 32'(amp_shunt), 32'd0);
    check("rst_duty", 32'(dut.duty_q), 32'd0);
    #10 rst = 1'b1;

    // Amplifier load
    a0 = amp_n;
    wait_amp(a0, ok);
    check("amp_done", 32'(ok), 32'd1);
    check("amp_bit_count", 32'(amp_n - a0), 32'd8);
    check("amp_gain", 32'(amp_bits), 32'h11);

    // Saturate low: measurement 0x80, setpoint 0
    p0 = pwm_hi;
    repeat (6) frame(14'h0000, 1'b0, 8'h00, "sat_low");
    check("sat_low_pwm_hi", 32'(pwm_hi - p0), 32'd0);

    // Ramp to 64, then hold with a=-1 (measurement 0x7F) and setpoint 0x7F
    for (int k = 0; k < 80 && model_duty < 64; k++) frame(14'h0000, 1'b0, 8'hFF, "ramp");
    repeat (10) frame(14'h3FFF, 1'b1, 8'h7F, "hold");
    pwm_window(64, "pwm_width_64");
    check("amp_once", 32'(cs_fall), 32'd1);

    // Random samples and setpoints
    repeat (20) begin
      ra = 14'($urandom);
      rr = 8'($urandom);
      frame(ra, 1'($urandom), rr, "random");
    end

    // Saturate high: measurement 0x80, setpoint 0xFF, must stop at 255
    for (int k = 0; k < 300 && model_duty < 255; k++) frame(14'h0000, 1'b0, 8'hFF, "sat_high");
    repeat (6) frame(14'h0000, 1'b0, 8'hFF, "sat_high_hold");
    pwm_window(255, "pwm_width_255");
    check("amp_once_end", 32'(cs_fall), 32'd1);

    // Reset asserted mid-READ
    wait_conv(ok);
    check("mid_conv_seen", 32'(ok), 32'd1);
    repeat (40) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_spi_clk", 32'(spi_clk), 32'd0);
    check("midrst_cs_amp", 32'(cs_amp), 32'd1);
    check("midrst_mosi", 32'(mosi), 32'd0);
    check("midrst_adc_conv", 32'(adc_conv), 32'd0);
    check("midrst_pwm", 32'(pwm), 32'd0);
    check("midrst_duty", 32'(dut.duty_q), 32'd0);
    check("midrst_cnt", 32'(dut.cnt_q), 32'd0);
    #20 rst = 1'b1;
    a0 = amp_n;
    wait_amp(a0, ok);
    check("reamp_done", 32'(ok), 32'd1);
    check("reamp_bit_count", 32'(amp_n - a0), 32'd8);
    check("reamp_gain", 32'(amp_bits), 32'h11);
    model_duty = 0;
    repeat (4) frame(14'h0000, 1'b0, 8'hFF, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modulo_general.md
MODULO_GENERAL -- requirements
Module: modulo_general

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per SPI_CLK half-period.
REQ-002 Parameter AMP_GAIN, default 8'h11: gain word sent to the programmable amplifier (gain -1 on both channels).
REQ-003 Parameter PWM_BITS, default 8: width of the duty register and the PWM counter.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock (50 MHz).
REQ-006 rst  in  1  asynchronous reset, active low.
REQ-007 referencia  in  8  unsigned setpoint.
REQ-008 MISO  in  1  ADC serial data.
REQ-009 MOSI  out  1  amplifier serial data.
REQ-010 SPI_CLK  out  1  shared SPI clock.
REQ-011 CS_AMP  out  1  amplifier chip select, active low.
REQ-012 ADC_Conv  out  1  ADC conversion start, active high.
REQ-013 PWM  out  1  actuator drive.
REQ-014 SPI_SS_B, DAC_CS, FPGA_INIT_B  out  1 each  deselects for other bus devices.
REQ-015 AMP_Shunt  out  1  amplifier shutdown, active high.

Function
REQ-016 SPI_SS_B, DAC_CS and FPGA_INIT_B SHALL be constant 1; AMP_Shunt SHALL be constant 0.
REQ-017 SPI_CLK SHALL idle low and toggle every CLK_DIV clk cycles only while a transfer is active.
REQ-018 MOSI SHALL change only while SPI_CLK is low; MISO SHALL be sampled on the SPI_CLK rising edge.
REQ-019 FSM states: AMP_LOAD, AMP_DONE, CONV, READ, UPDATE; after reset, go to AMP_LOAD.
REQ-020 AMP_LOAD: CS_AMP=0 and AMP_GAIN is shifted MSB first over 8 SPI_CLK cycles; then CS_AMP=1 for one SPI_CLK period (AMP_DONE), then CONV.
REQ-021 The amplifier SHALL be programmed only once per reset.
REQ-022 CONV: ADC_Conv=1 for one SPI_CLK period, then 0, then READ.
REQ-023 READ: 34 SPI_CLK cycles; bit indices 0..33; indices 2..15 are channel A (14-bit two's complement, MSB first); all other bits are discarded.
REQ-024 The measurement SHALL be the unsigned 8-bit value {~a[13], a[12:6]}.
REQ-025 UPDATE (one clk cycle): if referencia > measurement, duty+1, saturating at 255; if less, duty-1, saturating at 0; if equal, duty unchanged; then CONV.
REQ-026 The PWM counter SHALL be a free-running 8-bit counter on clk.
REQ-027 PWM SHALL be 1 when counter < duty: duty 0 gives constant 0, duty 255 gives 255/256 high.
REQ-028 A new duty value SHALL take effect at the next counter wrap (counter = 0), so no glitch is produced.
REQ-029 A change in referencia SHALL be honoured at the next UPDATE only; referencia is not registered at any other time.

Reset
REQ-030 While rst=0, the outputs SHALL be: MOSI=0, SPI_CLK=0, CS_AMP=1, ADC_Conv=0, PWM=0, with the constant outputs per REQ-016.
REQ-031 While rst=0, duty, the PWM counter, the shift registers and the divider SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately, and amplifier programming SHALL be redone after release.

Structure
REQ-033 The FSM state encoding, the bit-index constants (2, 15, 34) and the AMP_GAIN default SHALL live in a shared package.
REQ-034 One sub-module, spi_clk_gen (divider plus edge strobes), SHALL be used.
REQ-035 The FSM, shifters, controller and PWM SHALL be in the top module.

Verification
REQ-036 Reset: rst=0 for 100 ns -> CS_AMP=1, PWM=0, SPI_CLK=0, SPI_SS_B=DAC_CS=FPGA_INIT_B=1, AMP_Shunt=0.
REQ-037 Amplifier load: after release, MOSI at the 8 SPI_CLK rises with CS_AMP=0 reads 0,0,0,1,0,0,0,1; CS_AMP is then high with no further loads.
REQ-038 Saturate high: MISO=0 (measurement 0x80), referencia=0xFF -> duty +1 per frame, saturating at 255 and never wrapping.
REQ-039 Saturate low: MISO=0, referencia=0x00 -> duty stays 0 and PWM stays low.
REQ-040 Hold: MISO=1 (a=-1, measurement 0x7F), referencia=0x7F -> duty unchanged across 10 frames.
REQ-041 PWM width: duty=64 -> PWM high for exactly 64 of every 256 clk cycles; rst pulsed mid-READ -> outputs return to reset values asynchronously.
